// File: rtl/norm_mant.sv
// Post-addition normaliser: shifts the raw mantissa sum one bit per cycle until the
// hidden bit is set, then packs the single-precision result with ovf/unf flags.
module norm_mant #(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      in_ready,
    input  logic                      sign_in,
    input  logic [EXP_W-1:0]          exp_in,
    input  logic [MANT_W+1:0]         mant_sum,
    output logic [EXP_W+MANT_W:0]     result,
    output logic                      out_valid,
    input  logic                      out_ack,
    output logic                      ovf,
    output logic                      unf
);

    localparam int MW    = MANT_W + 2;
    localparam int RES_W = 1 + EXP_W + MANT_W;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t            state;
    logic              sign_r;
    logic [EXP_W-1:0]  exp_r;
    logic [MW-1:0]     mant_r;
    logic [EXP_W-1:0]  exp_inc;
    logic [MW-1:0]     mant_shr;

    function automatic logic [RES_W-1:0] pack(input logic s,
                                              input logic [EXP_W-1:0] e,
                                              input logic [MANT_W-1:0] f);
        return {s, e, f};
    endfunction

    assign in_ready = (state == IDLE);
    assign exp_inc  = exp_r + EXP_W'(1);
    assign mant_shr = mant_r >> 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            mant_r    <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_r <= sign_in;
                        exp_r  <= exp_in;
                        mant_r <= mant_sum;
                        ovf    <= 1'b0;
                        unf    <= 1'b0;
                        state  <= NORM;
                    end
                end
                NORM: begin
                    // Priority: carry, exact zero, normalised, underflow, left shift.
                    if (mant_r[MW-1]) begin
                        mant_r    <= mant_shr;
                        exp_r     <= exp_inc;
                        out_valid <= 1'b1;
                        state     <= DONE;
                        if (exp_inc == EXP_MAX) begin
                            ovf    <= 1'b1;
                            result <= pack(sign_r, EXP_MAX, '0);
                        end else begin
                            result <= pack(sign_r, exp_inc, mant_shr[MANT_W-1:0]);
                        end
                    end else if (mant_r == '0) begin
                        sign_r    <= 1'b0;
                        exp_r     <= '0;
                        result    <= pack(1'b0, '0, '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (mant_r[MANT_W]) begin
                        result    <= pack(sign_r, exp_r, mant_r[MANT_W-1:0]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (exp_r == EXP_W'(1)) begin
                        exp_r     <= '0;
                        mant_r    <= '0;
                        unf       <= 1'b1;
                        result    <= pack(sign_r, '0, '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        mant_r <= mant_r << 1;
                        exp_r  <= exp_r - EXP_W'(1);
                    end
                end
                DONE: begin
                    if (out_ack) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
